// File: rtl/sample_stream_rx.sv
// sample_stream_rx: 8N1 UART receiver that reassembles 3-byte, LSB-first
// 24-bit samples. Includes inter-byte timeout and stop-bit error recovery.
module sample_stream_rx #(
    parameter int unsigned CLK_FREQ     = 10000,
    parameter int unsigned BAUD         = 1000,
    parameter int unsigned TIMEOUT_BITS = 30
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [23:0] sample,
    output logic        sample_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned Div   = CLK_FREQ / BAUD;
    localparam int unsigned CntW  = $clog2(Div);
    localparam int unsigned TMax  = TIMEOUT_BITS * Div;
    localparam int unsigned TcntW = $clog2(TMax + 1);

    localparam logic [CntW-1:0]  CntHalf = CntW'(Div / 2 - 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(Div - 1);
    localparam logic [TcntW-1:0] TcntMax = TcntW'(TMax);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    logic             rx_meta_q, rx_s_q;
    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic [1:0]       idx_q;
    logic [15:0]      stg_q;
    logic [TcntW-1:0] tcnt_q;
    logic [7:0]       byte_data_q;
    logic             byte_valid_q;
    logic [23:0]      sample_q;
    logic             sample_valid_q;
    logic             frame_err_q;

    // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Bit FSM, byte assembler and inter-byte timeout, all with registered outputs.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shreg_q        <= '0;
            idx_q          <= '0;
            stg_q          <= '0;
            tcnt_q         <= '0;
            byte_data_q    <= '0;
            byte_valid_q   <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            byte_valid_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q   <= rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntFull) begin
                        cnt_q     <= '0;
                        shreg_q   <= {rx_s_q, shreg_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntFull) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            byte_data_q  <= shreg_q;
                            byte_valid_q <= 1'b1;
                            tcnt_q       <= '0;
                            state_q      <= StIdle;
                            case (idx_q)
                                2'd0: begin
                                    stg_q[7:0] <= shreg_q;
                                    idx_q      <= 2'd1;
                                end
                                2'd1: begin
                                    stg_q[15:8] <= shreg_q;
                                    idx_q       <= 2'd2;
                                end
                                2'd2: begin
                                    sample_q       <= {shreg_q, stg_q};
                                    sample_valid_q <= 1'b1;
                                    idx_q          <= 2'd0;
                                end
                                default: idx_q <= 2'd0;
                            endcase
                        end else begin
                            frame_err_q <= 1'b1;
                            idx_q       <= 2'd0;
                            tcnt_q      <= '0;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StBreak: begin
                    // Hold off until the line returns high so a stuck-low line is one error.
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Timeout only runs between bytes of a partial sample; it overrides idx even if a
            // start edge arrives in the same cycle, so that character becomes byte 0.
            if (state_q == StIdle && idx_q != 2'd0) begin
                if (tcnt_q == TcntMax) begin
                    idx_q       <= 2'd0;
                    tcnt_q      <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end
        end
    end

    assign byte_data    = byte_data_q;
    assign byte_valid   = byte_valid_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != StIdle) || (idx_q != 2'd0);

endmodule

// File: tb/tb_sample_stream_rx.sv
// Directed testbench for sample_stream_rx at DIV=10.
module tb_sample_stream_rx;

    localparam int Div = 10;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [23:0] sample;
    logic        sample_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Pulse counters and sample history collected by a passive monitor.
    int          bv_cnt = 0;
    int          sv_cnt = 0;
    int          fe_cnt = 0;
    int          sv_with_bv = 0;
    int          fe_with_sv = 0;
    logic [23:0] last_sample = '0;
    logic [23:0] prev_sample = '0;

    sample_stream_rx #(
        .CLK_FREQ    (10000),
        .BAUD        (1000),
        .TIMEOUT_BITS(30)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .sample      (sample),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (byte_valid === 1'b1) bv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (sample_valid === 1'b1) begin
            sv_cnt++;
            if (byte_valid === 1'b1) sv_with_bv++;
            if (frame_err === 1'b1) fe_with_sv++;
            prev_sample = last_sample;
            last_sample = sample;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_len);
        rx = 1'b0;
        repeat (Div) @(negedge clk1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Div) @(negedge clk1);
        end
        rx = 1'b1;
        repeat (stop_len) @(negedge clk1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk1);
        n_checks++;
        if (byte_data !== 8'h00) begin
            n_fails++; $display("FAIL reset_byte_data: got %h want 00", byte_data);
        end
        n_checks++;
        if (sample !== 24'h0) begin
            n_fails++; $display("FAIL reset_sample: got %h want 000000", sample);
        end
        n_checks++;
        if ({byte_valid, sample_valid, frame_err, busy} !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_flags: got %b want 0000",
                     {byte_valid, sample_valid, frame_err, busy});
        end
        rst_n = 1'b1;
        idle(5);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_sample();
        int b0, s0, c0, f0;
        b0 = bv_cnt; s0 = sv_cnt; c0 = sv_with_bv; f0 = fe_cnt;
        send_byte(8'h56, Div);
        send_byte(8'h34, Div);
        send_byte(8'h12, Div);
        idle(5);
        n_checks++;
        if (bv_cnt - b0 !== 3) begin
            n_fails++; $display("FAIL sample_bytes: got %0d want 3", bv_cnt - b0);
        end
        n_checks++;
        if (sv_cnt - s0 !== 1) begin
            n_fails++; $display("FAIL sample_pulses: got %0d want 1", sv_cnt - s0);
        end
        n_checks++;
        if (sv_with_bv - c0 !== 1) begin
            n_fails++; $display("FAIL sample_align: got %0d want 1", sv_with_bv - c0);
        end
        n_checks++;
        if (sample !== 24'h123456) begin
            n_fails++; $display("FAIL sample_value: got %h want 123456", sample);
        end
        n_checks++;
        if (byte_data !== 8'h12) begin
            n_fails++; $display("FAIL sample_last_byte: got %h want 12", byte_data);
        end
        n_checks++;
        if (fe_cnt - f0 !== 0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL sample_clean: got fe=%0d busy=%b want fe=0 busy=0", fe_cnt - f0, busy);
        end
    endtask

    task automatic test_glitch();
        int b0, f0;
        b0 = bv_cnt; f0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk1);
        rx = 1'b1;
        @(negedge clk1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++; $display("FAIL glitch_busy_high: got %b want 1", busy);
        end
        idle(20);
        n_checks++;
        if (bv_cnt - b0 !== 0 || fe_cnt - f0 !== 0) begin
            n_fails++;
            $display("FAIL glitch_no_pulse: got bv=%0d fe=%0d want 0 0", bv_cnt - b0, fe_cnt - f0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++; $display("FAIL glitch_busy_low: got %b want 0", busy);
        end
    endtask

    task automatic test_framing();
        int b0, s0, f0;
        b0 = bv_cnt; s0 = sv_cnt; f0 = fe_cnt;
        send_byte(8'h77, Div);
        send_byte(8'hA5, 0);
        rx = 1'b0;
        repeat (2 * Div) @(negedge clk1);
        idle(Div);
        n_checks++;
        if (fe_cnt - f0 !== 1) begin
            n_fails++; $display("FAIL framing_err_count: got %0d want 1", fe_cnt - f0);
        end
        n_checks++;
        if (bv_cnt - b0 !== 1 || byte_data !== 8'h77) begin
            n_fails++;
            $display("FAIL framing_byte: got n=%0d data=%h want n=1 data=77", bv_cnt - b0, byte_data);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++; $display("FAIL framing_busy: got %b want 0", busy);
        end
        send_byte(8'h01, Div);
        send_byte(8'h02, Div);
        send_byte(8'h03, Div);
        idle(5);
        n_checks++;
        if (sample !== 24'h030201 || sv_cnt - s0 !== 1) begin
            n_fails++;
            $display("FAIL framing_recover: got %h n=%0d want 030201 n=1", sample, sv_cnt - s0);
        end
        n_checks++;
        if (fe_cnt - f0 !== 1) begin
            n_fails++; $display("FAIL framing_err_once: got %0d want 1", fe_cnt - f0);
        end
    endtask

    task automatic test_timeout();
        int s0, f0;
        s0 = sv_cnt; f0 = fe_cnt;
        send_byte(8'h11, Div);
        send_byte(8'h22, Div);
        idle(31 * Div);
        n_checks++;
        if (fe_cnt - f0 !== 1) begin
            n_fails++; $display("FAIL timeout_err: got %0d want 1", fe_cnt - f0);
        end
        n_checks++;
        if (sample !== 24'h030201 || sv_cnt - s0 !== 0) begin
            n_fails++;
            $display("FAIL timeout_sample_kept: got %h n=%0d want 030201 n=0", sample, sv_cnt - s0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++; $display("FAIL timeout_busy: got %b want 0", busy);
        end
        send_byte(8'hAA, Div);
        send_byte(8'hBB, Div);
        send_byte(8'hCC, Div);
        idle(5);
        n_checks++;
        if (sample !== 24'hCCBBAA) begin
            n_fails++; $display("FAIL timeout_recover: got %h want ccbbaa", sample);
        end
        // A gap just under the limit must not abort the sample.
        f0 = fe_cnt;
        send_byte(8'h44, Div);
        idle(28 * Div);
        send_byte(8'h55, Div);
        send_byte(8'h66, Div);
        idle(5);
        n_checks++;
        if (sample !== 24'h665544 || fe_cnt - f0 !== 0) begin
            n_fails++;
            $display("FAIL timeout_near_limit: got %h fe=%0d want 665544 fe=0", sample, fe_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        int s0, f0;
        logic [7:0] b;
        send_byte(8'h5A, Div);
        b = 8'h3C;
        rx = 1'b0;
        repeat (Div) @(negedge clk1);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (Div) @(negedge clk1);
        end
        rx = b[4];
        repeat (Div / 2) @(negedge clk1);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk1);
        n_checks++;
        if (byte_data !== 8'h00 || sample !== 24'h0) begin
            n_fails++;
            $display("FAIL midreset_data: got %h %h want 00 000000", byte_data, sample);
        end
        n_checks++;
        if ({byte_valid, sample_valid, frame_err, busy} !== 4'b0000) begin
            n_fails++;
            $display("FAIL midreset_flags: got %b want 0000",
                     {byte_valid, sample_valid, frame_err, busy});
        end
        rst_n = 1'b1;
        idle(2 * Div);
        s0 = sv_cnt; f0 = fe_cnt;
        send_byte(8'h10, Div);
        send_byte(8'hFF, Div);
        send_byte(8'h00, Div);
        idle(5);
        n_checks++;
        if (sample !== 24'h00FF10 || sv_cnt - s0 !== 1 || fe_cnt - f0 !== 0) begin
            n_fails++;
            $display("FAIL midreset_frame: got %h sv=%0d fe=%0d want 00ff10 sv=1 fe=0",
                     sample, sv_cnt - s0, fe_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, s0, f0;
        b0 = bv_cnt; s0 = sv_cnt; f0 = fe_cnt;
        send_byte(8'hFF, Div);
        send_byte(8'hFF, Div);
        send_byte(8'hFF, Div + 1);
        send_byte(8'h00, Div);
        send_byte(8'h00, Div);
        send_byte(8'h00, Div);
        idle(5);
        n_checks++;
        if (bv_cnt - b0 !== 6 || sv_cnt - s0 !== 2) begin
            n_fails++;
            $display("FAIL b2b_counts: got bv=%0d sv=%0d want 6 2", bv_cnt - b0, sv_cnt - s0);
        end
        n_checks++;
        if (prev_sample !== 24'hFFFFFF || last_sample !== 24'h000000) begin
            n_fails++;
            $display("FAIL b2b_samples: got %h %h want ffffff 000000", prev_sample, last_sample);
        end
        n_checks++;
        if (fe_cnt - f0 !== 0 || fe_with_sv !== 0) begin
            n_fails++;
            $display("FAIL b2b_errors: got fe=%0d overlap=%0d want 0 0", fe_cnt - f0, fe_with_sv);
        end
    endtask

    initial begin
        @(negedge clk1);
        test_reset();
        test_sample();
        test_glitch();
        test_framing();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
